// File: rtl/subr_pkg.sv
// subr_pkg: shared types, constants and mod-3 helpers for the serial subtractor
//   state_t : IDLE / RUN / DONE controller states
//   CNT_W   : bit-counter width for the default 8-bit operand
//   mod3    : residue mod 3 of the low 'width' bits of a value
//   sub3    : (x - y) mod 3 for residues already in 0..2
package subr_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int W_DEF = 8;
    localparam int CNT_W = $clog2(W_DEF);

    function automatic logic [1:0] mod3(input logic [63:0] value, input int width);
        logic [1:0] r;
        logic [2:0] t;
        r = 2'd0;
        for (int i = 63; i >= 0; i--) begin
            if (i < width) begin
                // Horner step MSB first: r = (2r + bit) mod 3, with 2r + bit <= 5
                t = {r, value[i]};
                r = (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] sub3(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] t;
        t = {1'b0, x} + 3'd3 - {1'b0, y};
        return (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
    endfunction

endpackage

// File: rtl/fsub1.sv
// fsub1: combinational 1-bit full subtractor
//   a_i, b_i : minuend / subtrahend bit
//   bin      : borrow in
//   d        : difference bit
//   bout     : borrow out
module fsub1
    import subr_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a_i ^ b_i ^ bin;
    assign bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin);

endmodule

// File: rtl/subr8u_serial.sv
// subr8u_serial: bit-serial unsigned W-bit subtractor, LSB first, valid/ready on both sides
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (a, b captured on accept)
//   a, b                : minuend, subtrahend
//   out_valid, out_ready: result handshake
//   diff, borrow, err   : (a - b) mod 2^W, a < b, residue-check mismatch
// Optional macro SUBR_RESIDUE_CHECK_EN enables the mod-3 residue check on err;
// without it err is tied low.
module subr8u_serial
    import subr_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         err
);

    localparam int CW = $clog2(W);

    state_t        state, state_n;
    logic [W-1:0]  sa, sb;
    logic [CW-1:0] cnt;
    logic          bin, d, bout, last;

    assign last     = cnt == CW'(W - 1);
    assign in_ready = state == IDLE;

    fsub1 u_fsub1 (
        .a_i  (sa[0]),
        .b_i  (sb[0]),
        .bin  (bin),
        .d    (d),
        .bout (bout)
    );

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    always_comb begin
        state_n = state;
        if (state == IDLE && in_valid) state_n = RUN;
        if (state == RUN && last) state_n = DONE;
        if (state == DONE && out_ready) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa        <= '0;
            sb        <= '0;
            diff      <= '0;
            borrow    <= 1'b0;
            bin       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sa  <= a;
                    sb  <= b;
                    bin <= 1'b0;
                    cnt <= '0;
                end
                RUN: begin
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    diff <= {d, diff[W-1:1]};
                    bin  <= bout;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        borrow    <= bout;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef SUBR_RESIDUE_CHECK_EN
    // 2^W mod 3 is 1 for even W and 2 for odd W; it weights the borrow-out
    localparam logic [1:0] RK = (W % 2 == 0) ? 2'd1 : 2'd2;

    logic [1:0]   ra, rb;
    logic         err_q;
    logic [W-1:0] diff_n;

    assign diff_n = {d, diff[W-1:1]};
    assign err    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ra    <= 2'd0;
            rb    <= 2'd0;
            err_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            ra <= mod3(64'(a), W);
            rb <= mod3(64'(b), W);
        end else if (state == RUN && last) begin
            err_q <= sub3(mod3(64'(diff_n), W), bout ? RK : 2'd0) != sub3(ra, rb);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_subr8u_serial.sv
// tb_subr8u_serial: scoreboard bench for subr8u_serial (W = 8)
//   Expected diff/borrow are pushed when operands are accepted and popped by a
//   monitor when the result handshake occurs. Inputs change 3 time units after
//   the rising edge; outputs are sampled on the falling edge or after an edge.
module tb_subr8u_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, borrow, err;
    logic [W-1:0] diff;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bw;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    subr8u_serial #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.d  = x - y;
        e.bw = x < y;
        q.push_back(e);
    endtask

    task automatic op_start(input logic [W-1:0] x, input logic [W-1:0] y);
        int g;
        g = 0;
        while (!in_ready && g < 100) begin
            tick();
            g++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        a        = x;
        b        = y;
        in_valid = 1'b1;
        push(x, y);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int exp_lat);
        int lat;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("latency", lat, exp_lat);
    endtask

    task automatic complete();
        tick();
        check("out_valid_clear", out_valid, 0);
        check("in_ready_idle", in_ready, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = q.pop_front();
                check("diff", diff, e.d);
                check("borrow", borrow, e.bw);
                check("err", err, 0);
            end
        end
    end

    initial begin
        logic [W-1:0] va [7] = '{8'd200, 8'd55, 8'd0, 8'd0, 8'd0, 8'd255, 8'd128};
        logic [W-1:0] vb [7] = '{8'd55, 8'd200, 8'd1, 8'd0, 8'd255, 8'd255, 8'd127};
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            op_start(va[i], vb[i]);
            check("in_ready_run", in_ready, 0);
            wait_out(W);
            complete();
        end

        out_ready = 1'b0;
        op_start(8'd170, 8'd85);
        wait_out(W);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_diff", diff, 85);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        complete();

        op_start(8'd9, 8'd3);
        a        = 8'd1;
        b        = 8'd1;
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        wait_out(W - 3);
        complete();
        tick();
        tick();
        check("ignored_not_accepted", in_ready, 1);
        check("ignored_queue", q.size(), 0);

        op_start(8'd200, 8'd55);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete(q.size() - 1);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_diff", diff, 0);
        check("midrst_borrow", borrow, 0);
        tick();
        tick();
        check("midrst_no_result", out_valid, 0);
        op_start(8'd1, 8'd2);
        wait_out(W);
        complete();

        op_start(8'd100, 8'd30);
        wait_out(W);
        a        = 8'd5;
        b        = 8'd9;
        in_valid = 1'b1;
        tick();
        check("simul_out_valid", out_valid, 0);
        check("simul_idle", in_ready, 1);
        push(8'd5, 8'd9);
        tick();
        in_valid = 1'b0;
        check("simul_accepted", in_ready, 0);
        wait_out(W);
        complete();

        for (int i = 0; i < 12; i++) begin
            op_start(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
            wait_out(W);
            complete();
        end

        check("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
